// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised register file for the RISC-V datapath.
//            - NUM_RD combinational read ports.
//            - One synchronous write port (AD3/WD3/WE3).
//            - External input register IN_REG, loaded from ext_in.
//            - Hard-wired output tap a0 = reg[OUT_REG].
//            - Self-clearing sequencer: after reset or on clr_req, it zeroes
//              one register per clock. ready rises once the whole file is
//              zero.
// Ports    : clk     - rising-edge clock
//            rst     - asynchronous active-high reset
//            AD      - read addresses; port k is at [k*AW +: AW]
//            RD      - read data; port k is at [k*DW +: DW]
//            AD3     - write address
//            WE3     - write enable
//            WD3     - write data
//            in_EN   - load ext_in into IN_REG
//            ext_in  - external input value
//            clr_req - pulse that requests a re-clear (honoured in RUN only)
//            a0      - contents of OUT_REG
//            ready   - 1 when the file is usable (RUN state)
// Config   : REGFILE_BYPASS_EN - when defined, same-cycle write-through
//            forwarding on the RD ports and on a0.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int NUM_RD        = 2,
  parameter int OUT_REG       = 10,
  parameter int IN_REG        = 31
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*ADDRESS_WIDTH-1:0] AD,
  output logic [NUM_RD*DATA_WIDTH-1:0]    RD,
  input  logic [ADDRESS_WIDTH-1:0]        AD3,
  input  logic                            WE3,
  input  logic [DATA_WIDTH-1:0]           WD3,
  input  logic                            in_EN,
  input  logic [DATA_WIDTH-1:0]           ext_in,
  input  logic                            clr_req,
  output logic [DATA_WIDTH-1:0]           a0,
  output logic                            ready
);

  localparam int                     c_DEPTH    = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] c_LAST     = ADDRESS_WIDTH'(c_DEPTH - 1);
  localparam logic [ADDRESS_WIDTH-1:0] c_IN_ADDR  = ADDRESS_WIDTH'(IN_REG);
  localparam logic [ADDRESS_WIDTH-1:0] c_OUT_ADDR = ADDRESS_WIDTH'(OUT_REG);

  localparam logic [0:0] c_ST_CLEAR = 1'b0;
  localparam logic [0:0] c_ST_RUN   = 1'b1;

  logic [0:0]               r_state;
  logic [ADDRESS_WIDTH-1:0] r_cnt;
  logic                     r_ready;
  logic [DATA_WIDTH-1:0]    r_mem [c_DEPTH];

  logic w_run;
  logic w_we;
  logic w_in_wr;

  assign w_run   = (r_state == c_ST_RUN);
  // Register 0 is hard-wired to zero, so writes aimed at it are qualified
  // away here rather than being stored.
  assign w_we    = WE3 && (AD3 != '0);
  assign w_in_wr = in_EN && (c_IN_ADDR != '0);

  // --------------------------------------------------------------------------
  // Clear sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        c_ST_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_LAST) begin
            r_state <= c_ST_RUN;
            r_ready <= 1'b1;
          end
        end
        c_ST_RUN: begin
          if (clr_req) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
          end
        end
        default: begin
          r_state <= c_ST_CLEAR;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage. It has no reset: the sequencer zeroes it instead.
  // The WE3 write comes after the ext_in load, so when both target IN_REG
  // in the same cycle, the later non-blocking assignment (WD3) wins.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_in_wr) begin
        r_mem[c_IN_ADDR] <= ext_in;
      end
      if (w_we) begin
        r_mem[AD3] <= WD3;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read path shared by every RD lane and by a0.
  // --------------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] f_read(input logic [ADDRESS_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (w_run && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
      // Forwarding uses the same priority as the write: WE3 first, then ext_in.
      if (w_we && (addr == AD3)) begin
        v = WD3;
      end else if (w_in_wr && (addr == c_IN_ADDR)) begin
        v = ext_in;
      end else begin
        v = r_mem[addr];
      end
`else
      v = r_mem[addr];
`endif
    end
    return v;
  endfunction

  always_comb begin
    RD = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      RD[k*DATA_WIDTH +: DATA_WIDTH] = f_read(AD[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]);
    end
    a0 = f_read(c_OUT_ADDR);
  end

  assign ready = r_ready;

endmodule
`default_nettype wire
